// File: rtl/vec_mux_pipe_if.sv
// ---------------------------------------------------------------------------
// vec_mux_pipe_if
//   Bundles the upstream (candidate vectors + select + lane mask + valid/ready)
//   and downstream (result + error flag + valid/ready) signals of the vector
//   operand selector.
//
//   Parameters : N bits per lane, M lanes per vector, K candidate vectors.
//   Modports   : master - the side that offers transactions and consumes results
//                slave  - the selector itself (vec_mux_pipe)
//
//   Signals
//     in_data   [K-1:0][M-1:0][N-1:0] candidate vectors
//     sel       [SELW-1:0]            index of the vector to forward
//     lane_en   [M-1:0]               1 = lane takes the selected value
//     in_valid / in_ready             upstream handshake
//     out_data  [M-1:0][N-1:0]        registered result
//     out_err                         result came from an out-of-range select
//     out_valid / out_ready           downstream handshake
// ---------------------------------------------------------------------------
interface vec_mux_pipe_if #(
    parameter int N = 8,
    parameter int M = 16,
    parameter int K = 3
);
    localparam int SELW = $clog2(K);

    logic [K-1:0][M-1:0][N-1:0] in_data;
    logic [SELW-1:0]            sel;
    logic [M-1:0]               lane_en;
    logic                       in_valid;
    logic                       in_ready;
    logic [M-1:0][N-1:0]        out_data;
    logic                       out_err;
    logic                       out_valid;
    logic                       out_ready;

    modport master (
        output in_data, sel, lane_en, in_valid, out_ready,
        input  in_ready, out_data, out_err, out_valid
    );

    modport slave (
        input  in_data, sel, lane_en, in_valid, out_ready,
        output in_ready, out_data, out_err, out_valid
    );
endinterface

// File: rtl/vec_mux_pipe.sv
// ---------------------------------------------------------------------------
// vec_mux_pipe
//   K-input vector operand selector with a registered valid/ready output stage
//   and a 2-entry skid (output register + one skid register). Each accepted
//   transaction forwards in_data[sel], lane by lane, where lane_en is set;
//   disabled lanes take the fill value. sel >= K yields zero in the enabled
//   lanes and raises out_err. Latency is one cycle, throughput one per cycle.
//
//   Ports
//     clk    in  clock, all state on the rising edge
//     rst_n  in  asynchronous reset, active-low
//     bus    vec_mux_pipe_if.slave (in_data, sel, lane_en, in_valid, in_ready,
//            out_data, out_err, out_valid, out_ready)
//
//   Configuration macro
//     VEC_MUX_MERGE_EN  defined  : fill = last accepted result (merge base,
//                                  reset to 0, updated on every accept)
//                       undefined: fill = 0, no merge-base register
// ---------------------------------------------------------------------------
module vec_mux_pipe #(
    parameter int N = 8,
    parameter int M = 16,
    parameter int K = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    vec_mux_pipe_if.slave      bus
);
    localparam int SELW = $clog2(K);

    typedef logic [M-1:0][N-1:0] vec_t;

    // Output register and skid register state.
    logic out_valid_q, out_valid_d;
    vec_t out_data_q,  out_data_d;
    logic out_err_q,   out_err_d;
    logic skid_full_q, skid_full_d;
    vec_t skid_data_q, skid_data_d;
    logic skid_err_q,  skid_err_d;

    logic accept;
    logic pop;
    vec_t fill;
    vec_t sel_vec;
    logic sel_ok;
    vec_t res_data;
    logic res_err;

    // in_ready is a straight flop output, so there is no path from out_ready.
    assign accept = bus.in_valid & ~skid_full_q;
    assign pop    = out_valid_q & bus.out_ready;

    // Result computation for the transaction currently offered upstream.
    always_comb begin
        // NOTE: every variable written here gets a default first, otherwise a
        // path that skips the assignment would infer a latch.
        sel_vec = '0;
        sel_ok  = 1'b0;
        // Compare against each legal index instead of indexing with sel, so an
        // out-of-range select never reaches an out-of-bounds array access.
        for (int k = 0; k < K; k++) begin
            if (bus.sel == SELW'(k)) begin
                sel_vec = bus.in_data[k];
                sel_ok  = 1'b1;
            end
        end
        res_err = ~sel_ok;
        for (int i = 0; i < M; i++) begin
            res_data[i] = bus.lane_en[i] ? sel_vec[i] : fill[i];
        end
    end

`ifdef VEC_MUX_MERGE_EN
    // Merge base: last accepted result, error results included.
    vec_t merge_q, merge_d;

    always_comb begin
        merge_d = merge_q;
        if (accept) begin
            merge_d = res_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            merge_q <= '0;
        end else begin
            merge_q <= merge_d;
        end
    end

    assign fill = merge_q;
`else
    assign fill = '0;
`endif

    // Output-stage next state. When the skid holds data in_ready is low, so
    // no accept can coincide with a skid drain.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        skid_full_d = skid_full_q;
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;

        if (skid_full_q) begin
            if (pop) begin
                out_data_d  = skid_data_q;
                out_err_d   = skid_err_q;
                skid_full_d = 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q || bus.out_ready) begin
                // Output register free or being drained this cycle.
                out_valid_d = 1'b1;
                out_data_d  = res_data;
                out_err_d   = res_err;
            end else begin
                // Downstream stalled: park the result behind the held one.
                skid_full_d = 1'b1;
                skid_data_d = res_data;
                skid_err_d  = res_err;
            end
        end else if (pop) begin
            // out_data keeps its last value; only the valid flag drops.
            out_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before this edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            skid_full_q <= 1'b0;
            // NOTE: the skid payload is reset as well even though skid_full_q
            // already marks it empty; this keeps X out of the datapath.
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            skid_full_q <= skid_full_d;
            skid_data_q <= skid_data_d;
            skid_err_q  <= skid_err_d;
        end
    end

    assign bus.in_ready  = ~skid_full_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_vec_mux_pipe.sv
// ---------------------------------------------------------------------------
// tb_vec_mux_pipe
//   Randomised bench for vec_mux_pipe. A reference model keeps the ordered list
//   of results the block currently owes downstream (at most two), plus the
//   merge base when VEC_MUX_MERGE_EN is defined, and compares handshake flags
//   and output values every cycle.
// ---------------------------------------------------------------------------
module tb_vec_mux_pipe;
    localparam int N    = 8;
    localparam int M    = 16;
    localparam int K    = 3;
    localparam int SELW = $clog2(K);
    localparam int W    = M * N;
    localparam int DW   = K * M * N;

    typedef logic [M-1:0][N-1:0] vec_t;
    typedef struct {
        vec_t data;
        logic err;
    } item_t;

    logic clk;
    logic rst_n;

    item_t exp_q[$];
    vec_t  merge_base;
    int    n_tests;
    int    n_fail;
    int    n_accepted;

    vec_mux_pipe_if #(.N(N), .M(M), .K(K)) bus ();

    vec_mux_pipe #(.N(N), .M(M), .K(K)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Result of one transaction straight from the selection rules.
    function automatic item_t model(input logic [K-1:0][M-1:0][N-1:0] d,
                                    input logic [SELW-1:0] s,
                                    input logic [M-1:0] en);
        item_t       r;
        logic [W-1:0] base;
        logic [W-1:0] mask;
        logic [W-1:0] fill;
`ifdef VEC_MUX_MERGE_EN
        fill = merge_base;
`else
        fill = '0;
`endif
        if (int'(s) >= K) begin
            base  = '0;
            r.err = 1'b1;
        end else begin
            base  = d[s];
            r.err = 1'b0;
        end
        mask = '0;
        for (int i = 0; i < M; i++) begin
            if (en[i]) mask = mask | (W'({N{1'b1}}) << (i * N));
        end
        r.data = (base & mask) | (fill & ~mask);
        return r;
    endfunction

    // Compare outputs with what the model says the block owes downstream.
    task automatic check_outputs(input string tag);
        check({tag, "_out_valid"}, W'(bus.out_valid), W'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            check({tag, "_out_data"}, bus.out_data, exp_q[0].data);
            check({tag, "_out_err"},  W'(bus.out_err), W'(exp_q[0].err));
        end
    endtask

    // One clock cycle: called and returns at a falling edge.
    task automatic step(input logic v, input logic [SELW-1:0] s,
                        input logic [M-1:0] en, input logic rdy, input string tag);
        logic [DW-1:0] flat;
        logic          acc;
        logic          pop;
        item_t         r;
        for (int j = 0; j < DW / 32; j++) flat[j*32 +: 32] = $urandom();
        bus.in_data   = flat;
        bus.in_valid  = v;
        bus.sel       = s;
        bus.lane_en   = en;
        bus.out_ready = rdy;
        #1;
        check({tag, "_in_ready"}, W'(bus.in_ready), W'(exp_q.size() < 2));
        acc = v && (exp_q.size() < 2);
        pop = rdy && (exp_q.size() > 0);
        r   = model(bus.in_data, s, en);
        @(posedge clk);
        if (pop) void'(exp_q.pop_front());
        if (acc) begin
            exp_q.push_back(r);
            merge_base = r.data;
            n_accepted++;
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic idle(input logic rdy, input string tag);
        step(1'b0, '0, '0, rdy, tag);
    endtask

    initial begin
        logic [SELW-1:0] rs;
        logic [M-1:0]    ren;
        int              start;
        int              cycles;

        n_tests      = 0;
        n_fail       = 0;
        n_accepted   = 0;
        merge_base   = '0;
        rst_n        = 1'b0;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.sel      = '0;
        bus.lane_en  = '0;
        bus.out_ready = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_out_valid", W'(bus.out_valid), '0);
        check("rst_out_data",  bus.out_data, '0);
        check("rst_out_err",   W'(bus.out_err), '0);
        check("rst_in_ready",  W'(bus.in_ready), W'(1'b1));
        rst_n = 1'b1;
        @(negedge clk);

        // Plain forward of vector 1, one-cycle latency.
        step(1'b1, SELW'(1), '1, 1'b1, "sel1");
        // Out-of-range select, then a legal one clears the error.
        step(1'b1, SELW'(3), '1, 1'b1, "sel_oor");
        step(1'b1, SELW'(0), '1, 1'b1, "sel0");
        // Half mask: upper lanes zero or merged from the previous result.
        step(1'b1, SELW'(2), 16'h00FF, 1'b1, "mask_lo");
        step(1'b1, SELW'(1), 16'hF0F0, 1'b1, "mask_mix");
        step(1'b1, SELW'(3), 16'h0F0F, 1'b1, "mask_oor");
        idle(1'b1, "drain0");

        // Backpressure: two pushes fill output + skid, then drain in order.
        step(1'b1, SELW'(0), '1, 1'b0, "bp_v0");
        step(1'b1, SELW'(2), '1, 1'b0, "bp_v1");
        step(1'b1, SELW'(1), '1, 1'b0, "bp_blocked");
        idle(1'b0, "bp_hold");
        step(1'b1, SELW'(1), 16'h3C3C, 1'b1, "bp_pop0");
        idle(1'b1, "bp_pop1");
        idle(1'b1, "bp_pop2");
        idle(1'b1, "bp_empty");

        // Random stream with random backpressure.
        start  = n_accepted;
        cycles = 0;
        while ((n_accepted - start) < 100 && cycles < 3000) begin
            rs  = SELW'($urandom_range(0, K));
            ren = M'($urandom());
            step(($urandom_range(0, 9) < 7), rs, ren, $urandom_range(0, 1) == 1, "stream");
            cycles++;
        end
        check("stream_count", W'(n_accepted - start), W'(100));
        repeat (3) idle(1'b1, "stream_drain");

        // Reset with the skid full: state clears asynchronously.
        step(1'b1, SELW'(2), '1, 1'b0, "rst_fill0");
        step(1'b1, SELW'(0), '1, 1'b0, "rst_fill1");
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_out_valid", W'(bus.out_valid), '0);
        check("rst_async_in_ready",  W'(bus.in_ready), W'(1'b1));
        exp_q.delete();
        merge_base = '0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b1, "post_rst0");
        idle(1'b1, "post_rst1");
        // First result after reset sees a zero merge base.
        step(1'b1, SELW'(1), 16'h00FF, 1'b1, "post_rst_acc");
        idle(1'b1, "post_rst_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
